// File: rtl/music_sequencer_pkg.sv
// Shared types and constants for the note sequencer.
package music_sequencer_pkg;

    // One note table entry: end-of-table flag, silent note, length in tempo ticks, tone word.
    typedef struct packed {
        logic        last;
        logic        rest;
        logic [7:0]  len;
        logic [15:0] freq;
    } note_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_PLAY
    } seq_state_t;

    localparam logic [15:0] G4_FREQ  = 16'd4208;
    localparam logic [15:0] Dd4_FREQ = 16'd3339;
    localparam logic [15:0] Ad4_FREQ = 16'd5005;

    // A zero-length note still lasts one tick.
    function automatic logic [7:0] eff_len(input logic [7:0] len);
        return (len == 8'd0) ? 8'd1 : len;
    endfunction

endpackage

// File: rtl/music_sequencer_if.sv
// Control/config side of the sequencer: table writes, playback control and audio_channel drive.
interface music_sequencer_if #(
    parameter int DEPTH = 32
);
    import music_sequencer_pkg::*;

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic          wr_en_i;
    logic [AW-1:0] wr_addr_i;
    note_entry_t   wr_data_i;
    logic          start_i;
    logic          stop_i;
    logic          loop_i;
    logic [2:0]    gen_sel_i;
    logic [7:0]    volume_i;
    logic          en_o;
    logic [15:0]   freq_o;
    logic [2:0]    gen_sel_o;
    logic [7:0]    volume_o;
    logic          busy_o;
    logic [AW-1:0] note_idx_o;
    logic          done_o;

    modport master (
        output wr_en_i, wr_addr_i, wr_data_i, start_i, stop_i, loop_i, gen_sel_i, volume_i,
        input  en_o, freq_o, gen_sel_o, volume_o, busy_o, note_idx_o, done_o
    );

    modport slave (
        input  wr_en_i, wr_addr_i, wr_data_i, start_i, stop_i, loop_i, gen_sel_i, volume_i,
        output en_o, freq_o, gen_sel_o, volume_o, busy_o, note_idx_o, done_o
    );

endinterface

// File: rtl/music_sequencer_tick_gen.sv
// Tempo tick divider: one-cycle tick every TICK_DIV cycles while not cleared.
// Clear holds the count at its load value so the first tick after release
// arrives exactly TICK_DIV cycles later.
module music_sequencer_tick_gen #(
    parameter int TICK_DIV = 3125000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);
    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LOAD = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = ~clear & (cnt == '0);

    // Down-counter with terminal-count reload.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear || (cnt == '0)) begin
            cnt <= LOAD;
        end else begin
            cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/music_sequencer.sv
// Note sequencer: walks the note table and drives audio_channel en/freq/gen_sel/volume.
// The table is read on the edge entering FETCH, so the entry is ready during FETCH
// and the outputs change on the edge entering PLAY.
module music_sequencer
    import music_sequencer_pkg::*;
#(
    parameter int DEPTH    = 32,
    parameter int TICK_DIV = 3125000
) (
    input logic               clk_i,
    input logic               rst_i,
    music_sequencer_if.slave  bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    seq_state_t    state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [AW-1:0] note_idx_q, note_idx_d;
    logic          en_q, en_d;
    logic          done_q, done_d;
    logic          last_q, last_d;
    logic [15:0]   freq_q, freq_d;
    logic [2:0]    gen_sel_q, gen_sel_d;
    logic [7:0]    volume_q, volume_d;
    logic [7:0]    len_q, len_d;
    logic [7:0]    ticks_q, ticks_d;
    logic          tick;

    note_entry_t   mem [DEPTH];
    note_entry_t   rd_q;

    music_sequencer_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
        .clk   (clk_i),
        .rst   (rst_i),
        .clear (state_q != ST_PLAY),
        .tick  (tick)
    );

    // Note table: one write port, one registered read port addressed by the next index.
    always_ff @(posedge clk_i) begin
        if (bus.wr_en_i) begin
            mem[bus.wr_addr_i] <= bus.wr_data_i;
        end
        rd_q <= mem[idx_d];
    end

    // Next-state and output logic; stop wins over everything.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        note_idx_d = note_idx_q;
        en_d       = en_q;
        done_d     = 1'b0;
        last_d     = last_q;
        freq_d     = freq_q;
        gen_sel_d  = gen_sel_q;
        volume_d   = volume_q;
        len_d      = len_q;
        ticks_d    = ticks_q;
        unique case (state_q)
            ST_IDLE: begin
                en_d = 1'b0;
                if (bus.start_i && !bus.stop_i) begin
                    gen_sel_d = bus.gen_sel_i;
                    volume_d  = bus.volume_i;
                    idx_d     = '0;
                    state_d   = ST_FETCH;
                end
            end
            ST_FETCH: begin
                state_d    = ST_PLAY;
                freq_d     = rd_q.freq;
                en_d       = ~rd_q.rest;
                note_idx_d = idx_q;
                len_d      = rd_q.len;
                last_d     = rd_q.last;
                ticks_d    = '0;
            end
            ST_PLAY: begin
                if (tick) begin
                    if (ticks_q == (eff_len(len_q) - 8'd1)) begin
                        if (last_q || (idx_q == LAST_IDX)) begin
                            if (bus.loop_i) begin
                                idx_d   = '0;
                                state_d = ST_FETCH;
                            end else begin
                                state_d = ST_IDLE;
                                en_d    = 1'b0;
                                done_d  = 1'b1;
                            end
                        end else begin
                            idx_d   = idx_q + 1'b1;
                            state_d = ST_FETCH;
                        end
                    end else begin
                        ticks_d = ticks_q + 8'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (bus.stop_i) begin
            state_d = ST_IDLE;
            en_d    = 1'b0;
            done_d  = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            note_idx_q <= '0;
            en_q       <= 1'b0;
            done_q     <= 1'b0;
            last_q     <= 1'b0;
            freq_q     <= '0;
            gen_sel_q  <= '0;
            volume_q   <= '0;
            len_q      <= '0;
            ticks_q    <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            note_idx_q <= note_idx_d;
            en_q       <= en_d;
            done_q     <= done_d;
            last_q     <= last_d;
            freq_q     <= freq_d;
            gen_sel_q  <= gen_sel_d;
            volume_q   <= volume_d;
            len_q      <= len_d;
            ticks_q    <= ticks_d;
        end
    end

    assign bus.en_o       = en_q;
    assign bus.freq_o     = freq_q;
    assign bus.gen_sel_o  = gen_sel_q;
    assign bus.volume_o   = volume_q;
    assign bus.busy_o     = (state_q != ST_IDLE);
    assign bus.note_idx_o = note_idx_q;
    assign bus.done_o     = done_q;

endmodule
